// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one RAM port between fetch and LSU, with sub-word stores done as read-modify-write.
// Define RAM_ARB_RR_EN for round-robin arbitration; fixed LSU priority otherwise.
module ram_port_arbiter #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
)(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      if_req,
   input  logic [ADDR_WIDTH-1:0]     if_addr,
   output logic                      if_gnt,
   output logic                      if_rvalid,
   output logic [DATA_WIDTH-1:0]     if_rdata,
   input  logic                      ls_req,
   input  logic                      ls_we,
   input  logic [DATA_WIDTH/8-1:0]   ls_be,
   input  logic [ADDR_WIDTH-1:0]     ls_addr,
   input  logic [DATA_WIDTH-1:0]     ls_wdata,
   output logic                      ls_gnt,
   output logic                      ls_rvalid,
   output logic [DATA_WIDTH-1:0]     ls_rdata,
   output logic [ADDR_WIDTH-1:0]     mem_addr,
   output logic [DATA_WIDTH-1:0]     mem_wdata,
   output logic                      mem_we,
   input  logic [DATA_WIDTH-1:0]     mem_q
);
   localparam int BE_W = DATA_WIDTH / 8;
   typedef enum logic {IDLE, RMW_WR} state_t;
   state_t state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [BE_W-1:0] be_q, be_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d, merged;
   logic if_rvalid_q, if_rvalid_d, ls_rvalid_q, ls_rvalid_d;
   logic ls_win, if_win, ls_full, ls_partial, ls_pref, idle;
`ifdef RAM_ARB_RR_EN
   logic ls_pref_q, ls_pref_d;
   assign ls_pref = ls_pref_q;
`else
   assign ls_pref = 1'b1;
`endif
   assign if_rvalid = if_rvalid_q;
   assign ls_rvalid = ls_rvalid_q;
   assign if_rdata  = mem_q;
   assign ls_rdata  = mem_q;
   always_comb begin
      merged = mem_q;
      for (int i = 0; i < BE_W; i++)
         merged[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : mem_q[8*i +: 8];
      idle        = rst_n && state_q == IDLE;
      ls_full     = ls_we && &ls_be;
      ls_partial  = ls_we && |ls_be && !(&ls_be);
      ls_win      = idle && ls_req && (!if_req || ls_pref);
      if_win      = idle && if_req && !ls_win;
      ls_gnt      = ls_win;
      if_gnt      = if_win;
      mem_we      = rst_n && (state_q == RMW_WR || (ls_win && ls_full));
      mem_addr    = !rst_n ? '0 : state_q == RMW_WR ? addr_q : ls_win ? ls_addr : if_addr;
      mem_wdata   = !rst_n ? '0 : state_q == RMW_WR ? merged : ls_wdata;
      state_d     = ls_win && ls_partial ? RMW_WR : IDLE;
      addr_d      = ls_win && ls_partial ? ls_addr : addr_q;
      be_d        = ls_win && ls_partial ? ls_be : be_q;
      wdata_d     = ls_win && ls_partial ? ls_wdata : wdata_q;
      if_rvalid_d = if_win;
      // an RMW reports completion only after its write phase
      ls_rvalid_d = (ls_win && !ls_partial) || state_q == RMW_WR;
`ifdef RAM_ARB_RR_EN
      ls_pref_d   = idle && ls_req && if_req ? !ls_win : ls_pref_q;
`endif
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         be_q        <= '0;
         wdata_q     <= '0;
         if_rvalid_q <= 1'b0;
         ls_rvalid_q <= 1'b0;
`ifdef RAM_ARB_RR_EN
         ls_pref_q   <= 1'b1;
`endif
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         be_q        <= be_d;
         wdata_q     <= wdata_d;
         if_rvalid_q <= if_rvalid_d;
         ls_rvalid_q <= ls_rvalid_d;
`ifdef RAM_ARB_RR_EN
         ls_pref_q   <= ls_pref_d;
`endif
      end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: vector table, directed corner sequences and a randomized run against a transaction-level model.
module tb_ram_port_arbiter;
`ifdef RAM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif
   logic clk = 1'b0, rst_n = 1'b1;
   logic if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
   logic [9:0] if_addr = '0, ls_addr = '0;
   logic [3:0] ls_be = '0;
   logic [31:0] ls_wdata = '0;
   logic if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_we;
   logic [31:0] if_rdata, ls_rdata, mem_wdata, mem_q;
   logic [9:0] mem_addr;
   logic [31:0] ram [0:1023];
   logic bd_we = 1'b0;
   logic [9:0] bd_addr = '0;
   logic [31:0] bd_data = '0;
   int checks = 0, failures = 0;
   typedef struct {
      logic ir; logic [9:0] ia; logic lr, lw; logic [3:0] be; logic [9:0] la; logic [31:0] wd;
      logic eig, elg, ewe; logic [9:0] ea; logic [31:0] ed;
   } vec_t;
   vec_t vt [6];
   logic [31:0] rm [16];
   logic ev_l [4], ev_i [4];
   logic [31:0] ed_l [4], ed_i [4];
   logic busy, busy_n, pref, eg_l, eg_i, partial, exp_l;

   ram_port_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_q(mem_q));

   always #5 clk = ~clk;
   // write-first synchronous RAM with a backdoor preload path
   always @(posedge clk) begin
      if (bd_we) ram[bd_addr] <= bd_data;
      else if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_q <= mem_we ? mem_wdata : ram[mem_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic step;
      @(posedge clk); #1;
   endtask
   task automatic preload(input logic [9:0] a, input logic [31:0] d);
      bd_we = 1'b1; bd_addr = a; bd_data = d;
      step;
      bd_we = 1'b0;
   endtask
   function automatic logic [31:0] word(input int i);
      return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{1'b0, 10'h000, 1'b1, 1'b0, 4'h0, 10'h010, 32'h0, 1'b0, 1'b1, 1'b0, 10'h010, 32'hDEADBEEF};
      vt[1] = '{1'b1, 10'h040, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0, 1'b1, 1'b0, 1'b0, 10'h040, 32'hCAFEF00D};
      vt[2] = '{1'b1, 10'h040, 1'b1, 1'b0, 4'h0, 10'h010, 32'h0, 1'b0, 1'b1, 1'b0, 10'h010, 32'hDEADBEEF};
      vt[3] = '{1'b0, 10'h000, 1'b1, 1'b1, 4'hF, 10'h060, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b1, 10'h060, 32'hA5A5A5A5};
      vt[4] = '{1'b0, 10'h000, 1'b1, 1'b1, 4'h0, 10'h030, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 10'h030, 32'h00000055};
      vt[5] = '{1'b1, 10'h060, 1'b0, 1'b0, 4'h0, 10'h000, 32'h0, 1'b1, 1'b0, 1'b0, 10'h060, 32'hA5A5A5A5};
      // reset with both requesters active
      if_req = 1'b1; if_addr = 10'h155; ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'hF; ls_addr = 10'h3FF; ls_wdata = '1;
      #1 rst_n = 1'b0;
      #12;
      chk("rst if_gnt", if_gnt, 0);
      chk("rst ls_gnt", ls_gnt, 0);
      chk("rst mem_we", mem_we, 0);
      chk("rst mem_addr", mem_addr, 0);
      chk("rst mem_wdata", mem_wdata, 0);
      chk("rst if_rvalid", if_rvalid, 0);
      chk("rst ls_rvalid", ls_rvalid, 0);
      if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0; ls_be = '0;
      @(negedge clk) rst_n = 1'b1;
      step;
      preload(10'h010, 32'hDEADBEEF);
      preload(10'h040, 32'hCAFEF00D);
      preload(10'h030, 32'h00000055);
      preload(10'h020, 32'h11223344);
      preload(10'h070, 32'h11223344);
      for (int i = 0; i < 8; i++) preload(10'(i), word(i));
      foreach (vt[k]) begin
         if_req = vt[k].ir; if_addr = vt[k].ia; ls_req = vt[k].lr; ls_we = vt[k].lw;
         ls_be = vt[k].be; ls_addr = vt[k].la; ls_wdata = vt[k].wd;
         @(negedge clk);
         chk($sformatf("v%0d if_gnt", k), if_gnt, vt[k].eig);
         chk($sformatf("v%0d ls_gnt", k), ls_gnt, vt[k].elg);
         chk($sformatf("v%0d mem_we", k), mem_we, vt[k].ewe);
         chk($sformatf("v%0d mem_addr", k), mem_addr, vt[k].ea);
         if (vt[k].ewe) chk($sformatf("v%0d mem_wdata", k), mem_wdata, vt[k].wd);
         step;
         if_req = 1'b0; ls_req = 1'b0;
         @(negedge clk);
         chk($sformatf("v%0d ls_rvalid", k), ls_rvalid, vt[k].elg);
         chk($sformatf("v%0d if_rvalid", k), if_rvalid, vt[k].eig);
         chk($sformatf("v%0d rdata", k), vt[k].elg ? ls_rdata : if_rdata, vt[k].ed);
         step;
      end
      // partial store followed by a fetch of the same word
      ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'b0010; ls_addr = 10'h020; ls_wdata = 32'h0000AA00;
      @(negedge clk);
      chk("rmw gnt", ls_gnt, 1);
      chk("rmw rd we", mem_we, 0);
      chk("rmw rd addr", mem_addr, 10'h020);
      step;
      ls_req = 1'b0; if_req = 1'b1; if_addr = 10'h020;
      @(negedge clk);
      chk("rmw wr we", mem_we, 1);
      chk("rmw wr data", mem_wdata, 32'h1122AA44);
      chk("rmw wr addr", mem_addr, 10'h020);
      chk("rmw busy ls_gnt", ls_gnt, 0);
      chk("rmw busy if_gnt", if_gnt, 0);
      chk("rmw early rvalid", ls_rvalid, 0);
      step;
      @(negedge clk);
      chk("rmw ls_rvalid", ls_rvalid, 1);
      chk("rmw ls_rdata", ls_rdata, 32'h1122AA44);
      chk("rmw next if_gnt", if_gnt, 1);
      step;
      if_req = 1'b0;
      @(negedge clk);
      chk("rmw fetch rvalid", if_rvalid, 1);
      chk("rmw fetch rdata", if_rdata, 32'h1122AA44);
      step;
      // contention from a fresh reset
      rst_n = 1'b0;
      step;
      @(negedge clk) rst_n = 1'b1;
      step;
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 10'h010; if_req = 1'b1; if_addr = 10'h040;
      for (int c = 0; c < 4; c++) begin
         exp_l = RR ? (c % 2 == 0) : 1'b1;
         @(negedge clk);
         chk($sformatf("arb%0d ls_gnt", c), ls_gnt, exp_l);
         chk($sformatf("arb%0d if_gnt", c), if_gnt, !exp_l);
         step;
      end
      ls_req = 1'b0;
      @(negedge clk);
      chk("arb fetch gnt", if_gnt, 1);
      step;
      if_req = 1'b0;
      step;
      // streaming fetch
      if_req = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if_addr = k[9:0];
         @(negedge clk);
         chk($sformatf("stream%0d gnt", k), if_gnt, 1);
         if (k > 0) begin
            chk($sformatf("stream%0d rvalid", k), if_rvalid, 1);
            chk($sformatf("stream%0d rdata", k), if_rdata, word(k - 1));
         end
         step;
      end
      if_req = 1'b0;
      @(negedge clk);
      chk("stream last rvalid", if_rvalid, 1);
      chk("stream last rdata", if_rdata, word(7));
      step;
      @(negedge clk);
      chk("stream end rvalid", if_rvalid, 0);
      step;
      // reset during the write phase of an RMW
      ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'b0001; ls_addr = 10'h070; ls_wdata = 32'h000000FF;
      @(negedge clk);
      chk("rstrmw gnt", ls_gnt, 1);
      step;
      ls_req = 1'b0;
      chk("rstrmw we before", mem_we, 1);
      #1 rst_n = 1'b0;
      #1 chk("rstrmw we dropped", mem_we, 0);
      step;
      chk("rstrmw no rvalid", ls_rvalid, 0);
      step;
      @(negedge clk) rst_n = 1'b1;
      chk("rstrmw word kept", ram[10'h070], 32'h11223344);
      step;
      @(negedge clk);
      chk("rstrmw no rvalid after", ls_rvalid, 0);
      step;
      // randomized traffic against a transaction-level model
      for (int a = 0; a < 16; a++) begin
         rm[a] = $urandom;
         preload(10'(a), rm[a]);
      end
      for (int i = 0; i < 4; i++) begin ev_l[i] = 1'b0; ev_i[i] = 1'b0; end
      busy = 1'b0; pref = 1'b1;
      for (int c = 0; c < 610; c++) begin
         if (c < 600 && !if_req && $urandom_range(0, 2) != 0) begin
            if_req = 1'b1; if_addr = 10'($urandom_range(0, 15));
         end
         if (c < 600 && !ls_req && $urandom_range(0, 2) != 0) begin
            ls_req = 1'b1; ls_we = 1'($urandom_range(0, 1)); ls_addr = 10'($urandom_range(0, 15)); ls_wdata = $urandom;
            case ($urandom_range(0, 3))
               0: ls_be = 4'h0;
               1: ls_be = 4'hF;
               default: ls_be = 4'($urandom_range(1, 14));
            endcase
         end
         @(negedge clk);
         eg_l = !busy && ls_req && (!if_req || pref);
         eg_i = !busy && if_req && !eg_l;
         chk("rnd ls_gnt", ls_gnt, eg_l);
         chk("rnd if_gnt", if_gnt, eg_i);
         chk("rnd ls_rvalid", ls_rvalid, ev_l[c % 4]);
         chk("rnd if_rvalid", if_rvalid, ev_i[c % 4]);
         if (ev_l[c % 4]) chk("rnd ls_rdata", ls_rdata, ed_l[c % 4]);
         if (ev_i[c % 4]) chk("rnd if_rdata", if_rdata, ed_i[c % 4]);
         ev_l[c % 4] = 1'b0; ev_i[c % 4] = 1'b0;
         if (RR && !busy && ls_req && if_req) pref = !eg_l;
         busy_n = 1'b0;
         if (eg_i) begin
            ev_i[(c + 1) % 4] = 1'b1; ed_i[(c + 1) % 4] = rm[if_addr[3:0]];
         end
         if (eg_l) begin
            partial = ls_we && ls_be != 4'h0 && ls_be != 4'hF;
            if (ls_we)
               for (int b = 0; b < 4; b++)
                  if (ls_be[b]) rm[ls_addr[3:0]][8*b +: 8] = ls_wdata[8*b +: 8];
            ev_l[(c + (partial ? 2 : 1)) % 4] = 1'b1;
            ed_l[(c + (partial ? 2 : 1)) % 4] = rm[ls_addr[3:0]];
            busy_n = partial;
         end
         busy = busy_n;
         step;
         if (eg_l) ls_req = 1'b0;
         if (eg_i) if_req = 1'b0;
      end
      step;
      for (int a = 0; a < 16; a++) chk($sformatf("rnd ram[%0d]", a), ram[10'(a)], rm[a]);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
